rv_beat_packer: RTL
===================

# rv_beat_packer

Single-clock ready/valid width upsizer that packs up to RATIO consecutive IN_WIDTH beats into one RATIO*IN_WIDTH word. It sits directly downstream of the split async FIFO chain, on its read side in the consumer clock domain. It turns the narrow beat stream into wide words for the accelerator datapath. A word closes when it is full or when an input beat carries in_last; short words are zero-padded and carry a beat count.

## Interface
Parameters:
- IN_WIDTH, 64, width of one input beat
- RATIO, 4, beats per output word; power of two, >= 2
- CNT_W, $clog2(RATIO)+1, width of out_count (derived, not overridden)

Ports:
- clk  input  1  single clock; one clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid && in_ready
- in_data  input  IN_WIDTH  beat payload
- in_last  input  1  beat closes the current word
- out_valid  output  1  output word valid
- out_ready  input  1  consumer accepts word when out_valid && out_ready
- out_data  output  RATIO*IN_WIDTH  packed word
- out_count  output  CNT_W  number of valid lanes, 1..RATIO
- out_last  output  1  word was closed by in_last

## Operation
- The block holds an accumulator acc[RATIO*IN_WIDTH], a lane index idx[$clog2(RATIO)], and an output register (out_data, out_count, out_last, out_valid).
- Lane order is little-endian. The beat accepted at idx=k lands in acc[k*IN_WIDTH +: IN_WIDTH].
- A completing beat is an accepted beat with idx==RATIO-1 or in_last=1. On a completing beat:
  - out_data <= acc with the current beat merged and all lanes above k forced to 0
  - out_count <= k+1
  - out_last <= in_last
  - out_valid <= 1
  - idx <= 0
  - acc <= 0
- A non-completing accepted beat writes its lane and increments idx.
- in_ready = rst_n && (!out_valid || out_ready). in_ready must not depend combinationally on in_valid, in_data or in_last.
- A word is retired when out_valid && out_ready. If no completing beat arrives in the same cycle, out_valid <= 0.
- Retirement and a completing beat in the same cycle: the new word overwrites the output register and out_valid stays 1, so there is no bubble.
- While out_valid && !out_ready, out_data, out_count and out_last hold stable, and in_ready=0, so idx and acc are frozen.
- A partial word is never emitted without in_last; there is no timeout flush.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_count=0, out_last=0, idx=0, acc=0, in_ready=0. Any partial word in flight is discarded.
- The first accept is possible on the first rising edge after rst_n deasserts.
- Latency: out_valid rises on the edge that accepts the completing beat, i.e. the word is visible the cycle after that beat's handshake.
- Throughput: 1 beat/cycle sustained with out_ready=1, giving 1 word per RATIO cycles and never stalling input.
- A backpressure stall propagates to in_ready in the same cycle (combinational from out_valid/out_ready). This is the only combinational path.
- When in_last coincides with idx==RATIO-1, the word is treated as full: out_count=RATIO, out_last=1.

## Structure
- A shared package rv_pack_pkg holds:
  - a function for the lane-index width ($clog2(RATIO))
  - the CNT_W derivation
  - a typedef for the {count, last} sideband struct, reused by the matching downsizer
- There is no sub-module. The accumulator plus output register is one module of roughly 150 lines.
- The output stage stays inline rather than as a separate skid buffer: in_ready must remain registered-state-only.

## Test plan
(IN_WIDTH=8, RATIO=4 for all scenarios.)
- Full word: beats 0x11,0x22,0x33,0x44 (last=1 on the 4th), out_ready=1 -> one cycle later out_data=0x44332211, out_count=4, out_last=1, single out_valid pulse.
- Short words: 0xA1, 0xA2(last) -> 0x0000A2A1, count=2, last=1. Then 0x5C(last) -> 0x0000005C, count=1. The next word restarts at lane 0.
- Backpressure: word pending with out_ready=0 for 5 cycles -> in_ready=0 throughout, out_data/out_count/out_last unchanged. On release, the word retires and the next beat is accepted in the same cycle.
- Streaming: 12 beats 0x01..0x0C, in_valid=1, out_ready=1, no last -> words 0x04030201, 0x08070605, 0x0C0B0A09 at 4-cycle spacing. in_ready never drops; out_last=0, count=4.
- Simultaneous retire and complete: out_ready=1 in the same cycle as a completing beat -> out_valid stays 1 and out_data updates to the new word with no idle cycle.
- Reset mid-word: assert rst_n=0 asynchronously after 2 beats -> all outputs 0 immediately. After release, beats 0x77,0x88,0x99,0xAA -> 0xAA998877, with no leftover lanes.

Source files
------------

// File: rtl/rv_pack_pkg.sv
// Shared helpers for the ready/valid width converters (packer and matching downsizer).
// Holds the width derivations and the {count, last} sideband type.
package rv_pack_pkg;

   // Lane index width; a single-lane configuration still needs one bit.
   function automatic int idx_width(input int ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

   function automatic int cnt_width(input int ratio);
      return $clog2(ratio) + 1;
   endfunction

   localparam int SIDE_CNT_W = 8;

   typedef struct packed {
      logic [SIDE_CNT_W-1:0] count;
      logic                  last;
   } side_t;

endpackage

// File: rtl/rv_beat_packer.sv
// Ready/valid upsizer: packs up to RATIO narrow beats little-endian into one wide word,
// closing early on in_last with zero-padded upper lanes and a valid-lane count.
module rv_beat_packer
   import rv_pack_pkg::*;
#(
   parameter  int IN_WIDTH = 64,
   parameter  int RATIO    = 4,
   localparam int CNT_W    = cnt_width(RATIO)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [IN_WIDTH-1:0]       in_data,
   input  logic                      in_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [RATIO*IN_WIDTH-1:0] out_data,
   output logic [CNT_W-1:0]          out_count,
   output logic                      out_last
);

   localparam int IDX_W  = idx_width(RATIO);
   localparam int WORD_W = RATIO * IN_WIDTH;

   logic [WORD_W-1:0] acc_q, acc_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [WORD_W-1:0] out_data_q, out_data_d;
   logic [CNT_W-1:0]  out_count_q, out_count_d;
   logic              out_last_q, out_last_d;
   logic              out_valid_q, out_valid_d;

   logic              accept;
   logic              complete;
   logic [WORD_W-1:0] merged;

   // Ready depends only on registered state, never on the incoming beat.
   assign in_ready = rst_n && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign complete = accept && ((idx_q == IDX_W'(RATIO - 1)) || in_last);

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_count = out_count_q;
   assign out_last  = out_last_q;

   // Lanes below idx come from the accumulator, lanes above it are forced to zero.
   always_comb begin
      merged = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (k < int'(idx_q)) begin
            merged[k*IN_WIDTH +: IN_WIDTH] = acc_q[k*IN_WIDTH +: IN_WIDTH];
         end else if (k == int'(idx_q)) begin
            merged[k*IN_WIDTH +: IN_WIDTH] = in_data;
         end
      end
   end

   always_comb begin
      acc_d       = acc_q;
      idx_d       = idx_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (complete) begin
         out_data_d  = merged;
         out_count_d = CNT_W'(idx_q) + CNT_W'(1);
         out_last_d  = in_last;
         out_valid_d = 1'b1;
         idx_d       = '0;
         acc_d       = '0;
      end else if (accept) begin
         acc_d = merged;
         idx_d = idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= '0;
         idx_q       <= '0;
         out_data_q  <= '0;
         out_count_q <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule
